// File: rtl/pong_ball_if.sv
`default_nettype none
// ============================================================================
// Module      : pong_ball_if
// Description : Bundle between the playfield controller and the ball engine.
//               The controller side drives speed, recentre, serve and both
//               paddle corners. The engine side returns the ball position,
//               its direction and the score pulses.
//   s, guiwei, serve          : speed select, recentre level, serve pulse
//   body1_x/y, body2_x/y [9:0]: top-left corners of the left/right paddles
//   ball_x/y [9:0]            : top-left corner of the ball
//   x_dir, y_dir              : 1 = moving right / moving down
//   score_l, score_r          : one-cycle point pulses
// Revision    : 1.0 - initial release
// ============================================================================
interface pong_ball_if;
  logic       s;
  logic       guiwei;
  logic       serve;
  logic [9:0] body1_x;
  logic [9:0] body1_y;
  logic [9:0] body2_x;
  logic [9:0] body2_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       x_dir;
  logic       y_dir;
  logic       score_l;
  logic       score_r;

  modport master (
    output s, guiwei, serve, body1_x, body1_y, body2_x, body2_y,
    input  ball_x, ball_y, x_dir, y_dir, score_l, score_r
  );

  modport slave (
    input  s, guiwei, serve, body1_x, body1_y, body2_x, body2_y,
    output ball_x, ball_y, x_dir, y_dir, score_l, score_r
  );
endinterface
`default_nettype wire

// File: rtl/pong_ball.sv
`default_nettype none
// ============================================================================
// Module      : pong_ball
// Description : Ball engine for the two-player pong playfield. Moves the ball
//               2 px per axis on every move tick, bounces off the walls and
//               the paddles, and pulses a score when a paddle misses.
//   vga_clk : single clock, rising edge
//   sys_rst : synchronous active-high reset
//   bus     : pong_ball_if.slave (inputs: speed/recentre/serve/paddles,
//             outputs: ball position, direction, score pulses)
// Revision    : 1.0 - initial release
// ============================================================================
module pong_ball #(
  parameter int unsigned H_DISP     = 640,
  parameter int unsigned V_DISP     = 480,
  parameter int unsigned SLDE_W     = 10,
  parameter int unsigned BODY_W     = 10,
  parameter int unsigned BODY_L     = 80,
  parameter int unsigned BALL_W     = 10,
  parameter int unsigned SPEED_FAST = 80000,
  parameter int unsigned SPEED_SLOW = 190000,
  parameter int unsigned HOLD_TICKS = 60
) (
  input  wire logic   vga_clk,
  input  wire logic   sys_rst,
  pong_ball_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_SERVE  = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORED = 2'd2
  } state_t;

  localparam logic [9:0]  c_cx       = 10'(H_DISP / 2 - BALL_W / 2);
  localparam logic [9:0]  c_cy       = 10'(V_DISP / 2 - BALL_W / 2);
  localparam logic [21:0] c_fast_m1  = 22'(SPEED_FAST - 1);
  localparam logic [21:0] c_slow_m1  = 22'(SPEED_SLOW - 1);
  localparam logic [7:0]  c_hold     = 8'(HOLD_TICKS);
  // All geometry is compared 11 bits wide so sums never wrap.
  localparam logic [10:0] c_ball_w   = 11'(BALL_W);
  localparam logic [10:0] c_body_w   = 11'(BODY_W);
  localparam logic [10:0] c_body_l   = 11'(BODY_L);
  localparam logic [10:0] c_right_lim = 11'(H_DISP - 2);
  localparam logic [10:0] c_floor    = 11'(V_DISP - SLDE_W);
  localparam logic [10:0] c_ceil     = 11'(SLDE_W);
  localparam logic [10:0] c_left_lim = 11'd2;

  state_t      state_q, state_d;
  logic [21:0] div_cnt_q, div_cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic [9:0]  ball_x_q, ball_x_d;
  logic [9:0]  ball_y_q, ball_y_d;
  logic        x_dir_q, x_dir_d;
  logic        y_dir_q, y_dir_d;
  logic        score_l_q, score_l_d;
  logic        score_r_q, score_r_d;

  logic [21:0] w_speed_m1;
  logic        w_move_en;
  logic [10:0] w_bx, w_by, w_b1x, w_b1y, w_b2x, w_b2y;
  logic        w_ov1, w_ov2, w_hit_l, w_hit_r, w_miss_l, w_miss_r;
  logic        w_wall_b, w_wall_t;
  logic [7:0]  w_hold_inc;

  assign w_speed_m1 = bus.s ? c_fast_m1 : c_slow_m1;
  assign w_move_en  = (div_cnt_q == w_speed_m1);

  assign w_bx  = {1'b0, ball_x_q};
  assign w_by  = {1'b0, ball_y_q};
  assign w_b1x = {1'b0, bus.body1_x};
  assign w_b1y = {1'b0, bus.body1_y};
  assign w_b2x = {1'b0, bus.body2_x};
  assign w_b2y = {1'b0, bus.body2_y};

  assign w_ov1 = (w_by + c_ball_w > w_b1y) && (w_by < w_b1y + c_body_l);
  assign w_ov2 = (w_by + c_ball_w > w_b2y) && (w_by < w_b2y + c_body_l);

  assign w_hit_l = !x_dir_q && w_ov1 && (w_bx <= w_b1x + c_body_w) && (w_bx + c_ball_w > w_b1x);
  assign w_hit_r =  x_dir_q && w_ov2 && (w_bx + c_ball_w >= w_b2x) && (w_bx < w_b2x + c_body_w);

  // A paddle contact wins over the edge-of-field miss test.
  assign w_miss_l = !x_dir_q && (w_bx <= c_left_lim) && !w_hit_l;
  assign w_miss_r =  x_dir_q && (w_bx + c_ball_w >= c_right_lim) && !w_hit_r;

  assign w_wall_b =  y_dir_q && (w_by + c_ball_w >= c_floor);
  assign w_wall_t = !y_dir_q && (w_by <= c_ceil);

  assign w_hold_inc = hold_q + 8'd1;

  always_comb begin
    // >= rather than == keeps the divider bounded if s drops the limit mid-count.
    div_cnt_d = (div_cnt_q >= w_speed_m1) ? 22'd0 : div_cnt_q + 22'd1;
    state_d   = state_q;
    hold_d    = hold_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    x_dir_d   = x_dir_q;
    y_dir_d   = y_dir_q;
    score_l_d = 1'b0;
    score_r_d = 1'b0;

    if (bus.guiwei) begin
      state_d  = ST_SERVE;
      ball_x_d = c_cx;
      ball_y_d = c_cy;
      hold_d   = 8'd0;
    end else begin
      case (state_q)
        ST_SERVE: begin
          if (bus.serve) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (w_move_en) begin
            if (w_miss_l) begin
              score_r_d = 1'b1;
              x_dir_d   = 1'b0;
              y_dir_d   = 1'b1;
              state_d   = ST_SCORED;
            end else if (w_miss_r) begin
              score_l_d = 1'b1;
              x_dir_d   = 1'b1;
              y_dir_d   = 1'b1;
              state_d   = ST_SCORED;
            end else begin
              if (w_hit_l)      x_dir_d = 1'b1;
              else if (w_hit_r) x_dir_d = 1'b0;
              if (w_wall_b)      y_dir_d = 1'b0;
              else if (w_wall_t) y_dir_d = 1'b1;
              ball_x_d = x_dir_d ? ball_x_q + 10'd2 : ball_x_q - 10'd2;
              ball_y_d = y_dir_d ? ball_y_q + 10'd2 : ball_y_q - 10'd2;
            end
          end
        end
        ST_SCORED: begin
          if (w_move_en) begin
            if (w_hold_inc >= c_hold) begin
              state_d  = ST_SERVE;
              hold_d   = 8'd0;
              ball_x_d = c_cx;
              ball_y_d = c_cy;
            end else begin
              hold_d = w_hold_inc;
            end
          end
        end
        default: state_d = ST_SERVE;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q   <= ST_SERVE;
      div_cnt_q <= 22'd0;
      hold_q    <= 8'd0;
      ball_x_q  <= c_cx;
      ball_y_q  <= c_cy;
      x_dir_q   <= 1'b1;
      y_dir_q   <= 1'b1;
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      hold_q    <= hold_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      x_dir_q   <= x_dir_d;
      y_dir_q   <= y_dir_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
    end
  end

  assign bus.ball_x  = ball_x_q;
  assign bus.ball_y  = ball_y_q;
  assign bus.x_dir   = x_dir_q;
  assign bus.y_dir   = y_dir_q;
  assign bus.score_l = score_l_q;
  assign bus.score_r = score_r_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_ball.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_ball
// Description : Self-checking bench for pong_ball with a short divider and
//               hold time. A tick-level playfield model is compared with the
//               DUT every cycle; directed scenarios pin key positions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_ball;

  localparam int SF = 4;
  localparam int SS = 8;
  localparam int HT = 3;
  localparam int CX = 315;
  localparam int CY = 235;

  localparam int MODE_WAIT = 0;
  localparam int MODE_FLY  = 1;
  localparam int MODE_HOLD = 2;

  localparam int W_XDIR0 = 0;
  localparam int W_XDIR1 = 1;
  localparam int W_SCR_R = 2;
  localparam int W_SCR_L = 3;
  localparam int W_MOVE  = 4;
  localparam int W_HOME  = 5;

  logic vga_clk = 1'b0;
  logic sys_rst = 1'b1;

  pong_ball_if bus();

  pong_ball #(
    .SPEED_FAST (SF),
    .SPEED_SLOW (SS),
    .HOLD_TICKS (HT)
  ) dut (
    .vga_clk (vga_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- playfield model (tick level) ----------------
  int m_x = CX, m_y = CY, m_xd = 1, m_yd = 1, m_sl = 0, m_sr = 0;
  int m_div = 0, m_hold = 0, m_st = MODE_WAIT;

  always @(posedge vga_clk) begin : model
    int spd, nx, ny, nxd, nyd, nst, nhold, ndiv, nsl, nsr;
    int b1x, b1y, b2x, b2y;
    bit tick, ov1, ov2, hit1, hit2;
    spd  = bus.s ? SF : SS;
    tick = (m_div == spd - 1);
    ndiv = (m_div >= spd - 1) ? 0 : m_div + 1;
    nx = m_x; ny = m_y; nxd = m_xd; nyd = m_yd; nst = m_st; nhold = m_hold;
    nsl = 0; nsr = 0;
    b1x = int'(bus.body1_x); b1y = int'(bus.body1_y);
    b2x = int'(bus.body2_x); b2y = int'(bus.body2_y);
    if (sys_rst) begin
      nx = CX; ny = CY; nxd = 1; nyd = 1; nst = MODE_WAIT; nhold = 0; ndiv = 0;
    end else if (bus.guiwei) begin
      nx = CX; ny = CY; nst = MODE_WAIT; nhold = 0;
    end else if (m_st == MODE_WAIT) begin
      if (bus.serve) nst = MODE_FLY;
    end else if (m_st == MODE_FLY) begin
      if (tick) begin
        ov1  = (m_y + 10 > b1y) && (m_y < b1y + 80);
        ov2  = (m_y + 10 > b2y) && (m_y < b2y + 80);
        hit1 = (m_xd == 0) && ov1 && (m_x <= b1x + 10) && (m_x + 10 > b1x);
        hit2 = (m_xd == 1) && ov2 && (m_x + 10 >= b2x) && (m_x < b2x + 10);
        if (m_xd == 0 && m_x <= 2 && !hit1) begin
          nsr = 1; nxd = 0; nyd = 1; nst = MODE_HOLD;
        end else if (m_xd == 1 && m_x + 10 >= 638 && !hit2) begin
          nsl = 1; nxd = 1; nyd = 1; nst = MODE_HOLD;
        end else begin
          if (hit1) nxd = 1;
          if (hit2) nxd = 0;
          if (m_yd == 1 && m_y + 10 >= 470) nyd = 0;
          else if (m_yd == 0 && m_y <= 10) nyd = 1;
          nx = m_x + (nxd == 1 ? 2 : -2);
          ny = m_y + (nyd == 1 ? 2 : -2);
        end
      end
    end else begin
      if (tick) begin
        nhold = m_hold + 1;
        if (nhold >= HT) begin
          nst = MODE_WAIT; nx = CX; ny = CY; nhold = 0;
        end
      end
    end
    m_x <= nx; m_y <= ny; m_xd <= nxd; m_yd <= nyd; m_st <= nst;
    m_hold <= nhold; m_div <= ndiv; m_sl <= nsl; m_sr <= nsr;
  end

  always @(negedge vga_clk) begin
    if (cmp_on) begin
      chk("cyc_ball_x",  int'(bus.ball_x),  m_x);
      chk("cyc_ball_y",  int'(bus.ball_y),  m_y);
      chk("cyc_x_dir",   int'(bus.x_dir),   m_xd);
      chk("cyc_y_dir",   int'(bus.y_dir),   m_yd);
      chk("cyc_score_l", int'(bus.score_l), m_sl);
      chk("cyc_score_r", int'(bus.score_r), m_sr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic wait_for(input int what, input int budget, input string name, output int n);
    bit hit;
    int x0;
    hit = 1'b0;
    n   = 0;
    x0  = int'(bus.ball_x);
    while (!hit && n < budget) begin
      cyc(1);
      n++;
      case (what)
        W_XDIR0: hit = (bus.x_dir == 1'b0);
        W_XDIR1: hit = (bus.x_dir == 1'b1);
        W_SCR_R: hit = (bus.score_r == 1'b1);
        W_SCR_L: hit = (bus.score_l == 1'b1);
        W_MOVE:  hit = (int'(bus.ball_x) != x0);
        default: hit = (int'(bus.ball_x) == CX) && (int'(bus.ball_y) == CY);
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: event not seen in %0d cycles, required within %0d", name, n, budget);
    end
  endtask

  task automatic pulse_serve();
    bus.serve = 1'b1;
    cyc(1);
    bus.serve = 1'b0;
  endtask

  task automatic chk_ball(input string name, input int x, input int y, input int xd, input int yd);
    chk({name, "_x"},  int'(bus.ball_x), x);
    chk({name, "_y"},  int'(bus.ball_y), y);
    chk({name, "_xd"}, int'(bus.x_dir),  xd);
    chk({name, "_yd"}, int'(bus.y_dir),  yd);
  endtask

  initial begin
    int n;
    bus.s = 1'b1; bus.guiwei = 1'b0; bus.serve = 1'b0;
    bus.body1_x = 10'd55;  bus.body1_y = 10'd20;
    bus.body2_x = 10'd551; bus.body2_y = 10'd400;
    cyc(1);
    cmp_on = 1'b1;
    cyc(2);
    sys_rst = 1'b0;
    chk_ball("reset", CX, CY, 1, 1);
    chk("reset_score_l", int'(bus.score_l), 0);
    chk("reset_score_r", int'(bus.score_r), 0);

    // Idle in SERVE: ball must not move without a serve.
    cyc(100);
    chk_ball("idle", CX, CY, 1, 1);

    // Launch and measure tick spacing for both speeds.
    pulse_serve();
    wait_for(W_MOVE, 20, "first_move", n);
    chk_ball("first_move", 317, 237, 1, 1);
    wait_for(W_MOVE, 20, "tick_fast", n);
    chk("tick_fast_period", n, 4);
    bus.s = 1'b0;
    wait_for(W_MOVE, 20, "tick_slow", n);
    chk("tick_slow_period", n, 8);
    cyc(6);                              // divider now sits at 6
    bus.s = 1'b1;                        // limit drops below count: wrap, no tick
    wait_for(W_MOVE, 20, "tick_switch", n);
    chk("tick_switch_period", n, 5);

    // Bottom-right corner: wall and right paddle flip on one tick.
    wait_for(W_XDIR0, 1000, "corner", n);
    chk_ball("corner", 539, 459, 0, 0);

    // Top wall at (89,9), then left paddle at (55,20) returns the ball.
    wait_for(W_XDIR1, 2000, "left_hit", n);
    chk_ball("left_hit", 67, 35, 1, 1);

    // Recentre mid-play keeps directions and parks in SERVE.
    cyc(3);
    bus.guiwei = 1'b1;
    bus.body1_y = 10'd300;
    cyc(1);
    chk_ball("guiwei_play", CX, CY, 1, 1);
    bus.guiwei = 1'b0;
    cyc(20);
    chk_ball("guiwei_hold", CX, CY, 1, 1);

    // Same path again, paddle moved away: left miss at (1,97).
    pulse_serve();
    cyc(10);
    pulse_serve();                       // ignored while playing
    wait_for(W_SCR_R, 3000, "miss_left", n);
    chk_ball("miss_left", 1, 97, 0, 1);
    chk("miss_left_score_l", int'(bus.score_l), 0);
    cyc(1);
    chk("score_r_width", int'(bus.score_r), 0);
    chk("frozen_x", int'(bus.ball_x), 1);
    wait_for(W_HOME, 40, "hold_release", n);
    chk("hold_release_cycles", n, 11);
    chk_ball("after_hold", CX, CY, 0, 1);

    // Serve left/down, miss again, recentre during the hold.
    pulse_serve();
    wait_for(W_SCR_R, 2000, "miss_left2", n);
    cyc(2);
    bus.guiwei = 1'b1;
    cyc(1);
    chk_ball("guiwei_scored", CX, CY, 0, 1);
    bus.guiwei = 1'b0;
    cyc(30);
    chk_ball("guiwei_scored_hold", CX, CY, 0, 1);

    // Reset mid-play restores reset values.
    pulse_serve();
    cyc(40);
    sys_rst = 1'b1;
    cyc(1);
    chk_ball("mid_reset", CX, CY, 1, 1);
    sys_rst = 1'b0;

    // Right paddle parked at the top: right miss at (629,373).
    bus.body2_y = 10'd0;
    cyc(5);
    pulse_serve();
    wait_for(W_SCR_L, 2000, "miss_right", n);
    chk_ball("miss_right", 629, 373, 1, 1);
    chk("miss_right_score_r", int'(bus.score_r), 0);
    cyc(1);
    chk("score_l_width", int'(bus.score_l), 0);
    cyc(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
